// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the riscv data-memory bus.
//   - MMIO register byte addresses (LED, UART data, UART status, cycle counter)
//   - tgt_sel_t: which source supplies load data (RAM, MMIO register, nothing)
//   - uart_state_t: UART serializer frame states
package riscv_mmio_pkg;

  localparam logic [31:0] MMIO_LED       = 32'h8000_0000;
  localparam logic [31:0] MMIO_UART_DATA = 32'h8000_0004;
  localparam logic [31:0] MMIO_UART_STAT = 32'h8000_0008;
  localparam logic [31:0] MMIO_CYCLE     = 32'h8000_000C;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_MMIO,
    TGT_NONE
  } tgt_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter.
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset
//   data_in[7:0]    byte to send
//   valid_in        a byte is available on data_in
//   ready_out       byte is taken on any edge where valid_in && ready_out
//   tx_out          serial line, idles high
// Handshake: a transfer happens on a rising edge where valid_in and ready_out
// are both high; valid_in may be held indefinitely, ready_out depends only on
// internal state. ready_out is also high in the last STOP cycle so that a
// waiting byte starts its START bit with no idle gap.
module uart_tx_serializer
  import riscv_mmio_pkg::*;
#(
  parameter int CLKS_PER_BAUD = 868
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out
);

  localparam int BW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;

  uart_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          baud_last;

  assign baud_last = (baud_q == BW'(CLKS_PER_BAUD - 1));
  assign ready_out = (state_q == IDLE) || ((state_q == STOP) && baud_last);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_out  = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (valid_in) begin
          shift_d = data_in;
          state_d = START;
        end
      end
      START: begin
        tx_out = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_out = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_out = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (valid_in) begin
            shift_d = data_in;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_bus.sv
// Data-memory bus behind the riscv core data port.
// Decodes each access to the data BRAM, the MMIO registers (LED, UART data,
// UART status, cycle counter) or nothing, and returns load data exactly two
// cycles after the address for every target.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   dmem_addr_in/data_in      core byte address and store data
//   dmem_write_enable_in[3:0] per-byte store strobes
//   dmem_data_out             load data, valid 2 cycles after its address
//   ram_addr_out/data_out/we_out, ram_data_in   BRAM port (read data lands
//                             one edge after the address; the bus registers it
//                             once more, giving the 2-cycle total)
//   led_out                   LED register
//   uart_tx_out               serial TX line
module riscv_dmem_bus
  import riscv_mmio_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 14,
  parameter int CLKS_PER_BAUD = 868,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [31:0]              dmem_addr_in,
  input  logic [31:0]              dmem_data_in,
  input  logic [3:0]               dmem_write_enable_in,
  output logic [31:0]              dmem_data_out,
  output logic [RAM_ADDR_BITS-1:0] ram_addr_out,
  output logic [31:0]              ram_data_out,
  output logic [3:0]               ram_we_out,
  input  logic [31:0]              ram_data_in,
  output logic [15:0]              led_out,
  output logic                     uart_tx_out
);

  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Address decode
  logic        is_ram;
  tgt_sel_t    sel;
  logic [31:0] mmio_rd;
  logic [31:0] stat;
  logic [31:0] cycle_q;
  logic [31:0] count_ext;

  // TX FIFO
  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_nonempty;
  logic             push_req, push_ok, pop, ovf_clr, overflow_q;
  logic             ser_ready, tx_busy;

  // Read pipeline stage 1
  tgt_sel_t    sel_q;
  logic [31:0] mmio_q;

  // Everything below 2^(RAM_ADDR_BITS+2) bytes is RAM; this also requires addr[31] = 0.
  assign is_ram       = ((dmem_addr_in >> (RAM_ADDR_BITS + 2)) == 32'd0);
  assign ram_addr_out = dmem_addr_in[RAM_ADDR_BITS+1:2];
  assign ram_data_out = dmem_data_in;
  assign ram_we_out   = (is_ram && !rst_in) ? dmem_write_enable_in : 4'b0000;

  assign fifo_full     = (fifo_count == CNT_W'(TX_FIFO_DEPTH));
  assign fifo_nonempty = (fifo_count != '0);
  assign push_req      = (dmem_addr_in == MMIO_UART_DATA) && dmem_write_enable_in[0];
  assign push_ok       = push_req && !fifo_full;
  assign pop           = fifo_nonempty && ser_ready && !rst_in;
  assign ovf_clr       = (dmem_addr_in == MMIO_UART_STAT) && dmem_write_enable_in[0]
                         && dmem_data_in[2];
  // Serializer not ready means a frame is on the wire.
  assign tx_busy       = !ser_ready || fifo_nonempty;

  assign count_ext = 32'(fifo_count);
  assign stat      = {24'h0, count_ext[4:0], overflow_q, fifo_full, tx_busy};

  always_comb begin
    sel     = TGT_NONE;
    mmio_rd = 32'h0;
    if (is_ram) begin
      sel = TGT_RAM;
    end else begin
      case (dmem_addr_in)
        MMIO_LED:       begin sel = TGT_MMIO; mmio_rd = {16'h0, led_out}; end
        MMIO_UART_DATA: begin sel = TGT_MMIO; mmio_rd = 32'h0; end
        MMIO_UART_STAT: begin sel = TGT_MMIO; mmio_rd = stat; end
        MMIO_CYCLE:     begin sel = TGT_MMIO; mmio_rd = cycle_q; end
        default:        begin sel = TGT_NONE; mmio_rd = 32'h0; end
      endcase
    end
  end

  // MMIO registers, cycle counter and read pipeline
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      led_out       <= '0;
      cycle_q       <= '0;
      sel_q         <= TGT_NONE;
      mmio_q        <= '0;
      dmem_data_out <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (dmem_addr_in == MMIO_LED) begin
        if (dmem_write_enable_in[0]) led_out[7:0]  <= dmem_data_in[7:0];
        if (dmem_write_enable_in[1]) led_out[15:8] <= dmem_data_in[15:8];
      end
      sel_q  <= sel;
      mmio_q <= mmio_rd;
      case (sel_q)
        TGT_RAM:  dmem_data_out <= ram_data_in;
        TGT_MMIO: dmem_data_out <= mmio_q;
        default:  dmem_data_out <= 32'h0;
      endcase
    end
  end

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (push_ok && !rst_in) fifo_mem[wr_ptr] <= dmem_data_in[7:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && fifo_full) overflow_q <= 1'b1;
      else if (ovf_clr)          overflow_q <= 1'b0;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_ser (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (fifo_mem[rd_ptr]),
    .valid_in (fifo_nonempty),
    .ready_out(ser_ready),
    .tx_out   (uart_tx_out)
  );

endmodule

// File: tb/tb_riscv_dmem_bus.sv
module tb_riscv_dmem_bus;

  localparam logic [31:0] A_LED  = 32'h8000_0000;
  localparam logic [31:0] A_UD   = 32'h8000_0004;
  localparam logic [31:0] A_US   = 32'h8000_0008;
  localparam logic [31:0] A_CYC  = 32'h8000_000C;
  localparam logic [31:0] A_UNM  = 32'h4000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [15:0] led;
  logic        tx;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  riscv_dmem_bus #(
    .RAM_ADDR_BITS(14),
    .CLKS_PER_BAUD(4),
    .TX_FIFO_DEPTH(16)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .dmem_addr_in        (addr),
    .dmem_data_in        (wdata),
    .dmem_write_enable_in(we),
    .dmem_data_out       (rdata),
    .ram_addr_out        (ram_addr),
    .ram_data_out        (ram_wdata),
    .ram_we_out          (ram_we),
    .ram_data_in         (ram_rdata),
    .led_out             (led),
    .uart_tx_out         (tx)
  );

  // BRAM model: read data appears one edge after the address (read-before-write)
  logic [31:0] bmem [256];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) bmem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= bmem[ram_addr[7:0]];
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; we = s;
    tick();
    we = 4'h0;
    addr = A_UNM;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 4'h0;
    tick();
    tick();
    d = rdata;
    addr = A_UNM;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1; addr = 32'h40; wdata = 32'h1234_5678; we = 4'hF;
    tick();
    tick();
    total++;
    if (ram_we !== 4'h0) $display("FAIL reset_ram_we: got %h expected 0", ram_we);
    else passed++;
    total++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata);
    else passed++;
    total++;
    if (led !== 16'h0) $display("FAIL reset_led: got %h expected 0", led);
    else passed++;
    total++;
    if (tx !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx);
    else passed++;
    we = 4'h0; addr = A_UNM;
    rst = 1'b0;
    tick();                        // counter 0 -> 1 on this edge
    bus_read(A_CYC, v);            // stage-1 edge samples 1
    total++;
    if (v !== 32'd1) $display("FAIL reset_cycle: got %0d expected 1", v);
    else passed++;
  endtask

  task automatic test_ram();
    logic [31:0] v;
    addr = 32'h40; wdata = 32'hCAFE_BABE; we = 4'hF;
    #1;
    total++;
    if (ram_addr !== 14'h10) $display("FAIL ram_addr: got %h expected 10", ram_addr);
    else passed++;
    total++;
    if (ram_we !== 4'hF) $display("FAIL ram_we_write: got %h expected F", ram_we);
    else passed++;
    tick();
    we = 4'h0;
    bus_read(32'h40, v);
    total++;
    if (v !== 32'hCAFE_BABE) $display("FAIL ram_read: got %h expected cafebabe", v);
    else passed++;
    bus_write(32'h44, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h44, 32'h1122_3344, 4'h3);
    bus_read(32'h44, v);
    total++;
    if (v !== 32'hFFFF_3344) $display("FAIL ram_partial: got %h expected ffff3344", v);
    else passed++;
    // top of RAM is mapped, one word beyond is not
    addr = 32'h0000_FFFC; we = 4'hF; #1;
    total++;
    if (ram_we !== 4'hF) $display("FAIL ram_top_we: got %h expected F", ram_we);
    else passed++;
    addr = 32'h0001_0000; #1;
    total++;
    if (ram_we !== 4'h0) $display("FAIL ram_beyond_we: got %h expected 0", ram_we);
    else passed++;
    we = 4'h0; addr = A_UNM;
    tick();
  endtask

  task automatic test_led();
    logic [31:0] v;
    addr = A_LED; wdata = 32'h0000_12AB; we = 4'b0001; #1;
    total++;
    if (ram_we !== 4'h0) $display("FAIL led_ram_we: got %h expected 0", ram_we);
    else passed++;
    tick();
    we = 4'h0; addr = A_UNM;
    total++;
    if (led !== 16'h00AB) $display("FAIL led_byte0: got %h expected 00ab", led);
    else passed++;
    bus_read(A_LED, v);
    total++;
    if (v !== 32'h0000_00AB) $display("FAIL led_read: got %h expected 000000ab", v);
    else passed++;
    bus_write(A_LED, 32'hFFFF_5600, 4'b1110);
    total++;
    if (led !== 16'h56AB) $display("FAIL led_byte1: got %h expected 56ab", led);
    else passed++;
    // read in the same cycle as a write returns the old value
    addr = A_LED; wdata = 32'h0000_0011; we = 4'b0001;
    tick();
    we = 4'h0;
    tick();
    addr = A_UNM;
    total++;
    if (rdata !== 32'h0000_56AB) $display("FAIL led_rw_old: got %h expected 000056ab", rdata);
    else passed++;
    total++;
    if (led !== 16'h5611) $display("FAIL led_rw_new: got %h expected 5611", led);
    else passed++;
  endtask

  task automatic test_uart_frame();
    logic [31:0] v;
    logic [9:0]  pat;
    logic        found;
    int          bad;
    pat = {1'b1, 8'h55, 1'b0};
    bus_write(A_UD, 32'h0000_0055, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx === 1'b0) begin found = 1'b1; break; end
      tick();
    end
    total++;
    if (!found) $display("FAIL uart_start_timeout: got no start bit expected one within 10 cycles");
    else passed++;
    if (found) begin
      for (int c = 0; c < 40; c += 4) begin
        bad = 0;
        for (int k = 0; k < 4; k++) begin
          if (tx !== pat[c/4]) bad++;
          tick();
        end
        total++;
        if (bad != 0) $display("FAIL uart_cell%0d: got %0d wrong cycles expected level %b", c/4, bad, pat[c/4]);
        else passed++;
      end
    end
    bus_read(A_US, v);
    total++;
    if (v !== 32'h0) $display("FAIL uart_idle_stat: got %h expected 0", v);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    for (int i = 0; i < 18; i++) begin
      addr = A_UD; wdata = 32'(i + 8'h30); we = 4'b0001;
      tick();
    end
    we = 4'h0;
    bus_read(A_US, v);
    total++;
    if (v !== 32'h87) $display("FAIL ovf_stat: got %h expected 87", v);
    else passed++;
    bus_write(A_US, 32'h4, 4'b0001);
    bus_read(A_US, v);
    total++;
    if (v !== 32'h83) $display("FAIL ovf_clear: got %h expected 83", v);
    else passed++;
    do_reset();
    bus_read(A_US, v);
    total++;
    if (v !== 32'h0) $display("FAIL ovf_after_reset: got %h expected 0", v);
    else passed++;
  endtask

  task automatic test_cycle_unmapped();
    logic [31:0] v1, v2, v;
    bus_read(A_CYC, v1);
    for (int i = 0; i < 8; i++) tick();
    bus_read(A_CYC, v2);
    total++;
    if (v2 - v1 !== 32'd10) $display("FAIL cycle_delta: got %0d expected 10", v2 - v1);
    else passed++;
    bus_read(A_UNM, v);
    total++;
    if (v !== 32'h0) $display("FAIL unmapped_read: got %h expected 0", v);
    else passed++;
    bus_write(A_LED, 32'h0000_BEEF, 4'b0011);
    addr = A_UNM; wdata = 32'hDEAD_0000; we = 4'hF; #1;
    total++;
    if (ram_we !== 4'h0) $display("FAIL unmapped_ram_we: got %h expected 0", ram_we);
    else passed++;
    tick();
    we = 4'h0;
    total++;
    if (led !== 16'hBEEF) $display("FAIL unmapped_led: got %h expected beef", led);
    else passed++;
    bus_write(32'h40, 32'hCAFE_BABE, 4'hF);
    bus_write(A_UNM, 32'h1111_2222, 4'hF);
    bus_read(32'h40, v);
    total++;
    if (v !== 32'hCAFE_BABE) $display("FAIL unmapped_ram_kept: got %h expected cafebabe", v);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    logic        found;
    int          bad;
    bus_write(A_LED, 32'h0000_1234, 4'b0011);
    bus_write(A_UD, 32'h0000_00F0, 4'b0001);
    addr = A_LED;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx === 1'b0) begin found = 1'b1; break; end
      tick();
    end
    total++;
    if (!found) $display("FAIL mid_start_timeout: got no start bit expected one within 10 cycles");
    else passed++;
    for (int i = 0; i < 17; i++) tick();   // inside data bit 3 (0 for 0xF0)
    total++;
    if (tx !== 1'b0) $display("FAIL mid_bit3: got %b expected 0", tx);
    else passed++;
    total++;
    if (rdata !== 32'h1234) $display("FAIL mid_pre_rdata: got %h expected 1234", rdata);
    else passed++;
    rst = 1'b1;
    tick();
    total++;
    if (tx !== 1'b1) $display("FAIL mid_tx: got %b expected 1", tx);
    else passed++;
    total++;
    if (led !== 16'h0) $display("FAIL mid_led: got %h expected 0", led);
    else passed++;
    total++;
    if (rdata !== 32'h0) $display("FAIL mid_rdata: got %h expected 0", rdata);
    else passed++;
    rst = 1'b0;
    addr = A_UNM;
    bus_read(A_US, v);
    total++;
    if (v !== 32'h0) $display("FAIL mid_stat: got %h expected 0", v);
    else passed++;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    total++;
    if (bad != 0) $display("FAIL mid_line_quiet: got %0d low cycles expected 0", bad);
    else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; addr = A_UNM; wdata = 32'h0; we = 4'h0;
    test_reset();
    test_ram();
    test_led();
    test_uart_frame();
    test_overflow();
    test_cycle_unmapped();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
